// File: rtl/y86_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | y86_pkg : Y86-64 stat/icode encodings and control FSM states; r1.0 |
// +--------------------------------------------------------------------+
package y86_pkg;

  localparam logic [1:0] c_STAT_AOK = 2'd0;
  localparam logic [1:0] c_STAT_HLT = 2'd1;
  localparam logic [1:0] c_STAT_ADR = 2'd2;
  localparam logic [1:0] c_STAT_INS = 2'd3;

  localparam logic [3:0] c_I_HALT   = 4'h0;
  localparam logic [3:0] c_I_NOP    = 4'h1;
  localparam logic [3:0] c_I_RRMOVQ = 4'h2;
  localparam logic [3:0] c_I_IRMOVQ = 4'h3;
  localparam logic [3:0] c_I_RMMOVQ = 4'h4;
  localparam logic [3:0] c_I_MRMOVQ = 4'h5;
  localparam logic [3:0] c_I_OPQ    = 4'h6;
  localparam logic [3:0] c_I_JXX    = 4'h7;
  localparam logic [3:0] c_I_CALL   = 4'h8;
  localparam logic [3:0] c_I_RET    = 4'h9;
  localparam logic [3:0] c_I_PUSHQ  = 4'hA;
  localparam logic [3:0] c_I_POPQ   = 4'hB;

  localparam logic [3:0] c_RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } run_state_e;

  // Any non-AOK status is an exception from the pipeline's point of view.
  function automatic logic is_exc(input logic [1:0] stat);
    return stat != c_STAT_AOK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : clearable up-counter that sticks at all-ones; r1.0   |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : Y86-64 stall/bubble control, run FSM, counters  |
// | Revision : r1.0                                                    |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_stall,
  output logic             E_bubble,
  output logic             M_stall,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             W_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  import y86_pkg::*;

  localparam logic [3:0] c_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  run_state_e r_state;
  logic [3:0] r_flush_cnt;
  logic [1:0] r_halt_stat;

  logic w_lu, w_mp, w_rt, w_exc;
  logic w_in_run, w_in_halt;

  always_comb begin
    w_lu  = ((E_icode == c_I_MRMOVQ) || (E_icode == c_I_POPQ)) &&
            (E_dstM != c_RNONE) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    w_mp  = (E_icode == c_I_JXX) && !e_Cnd;
    w_rt  = (D_icode == c_I_RET) || (E_icode == c_I_RET) || (M_icode == c_I_RET);
    w_exc = is_exc(m_stat) || is_exc(W_stat);
  end

  // An asserted reset forces FLUSH behaviour on the outputs before the edge lands.
  assign w_in_run  = rst_n && (r_state == ST_RUN);
  assign w_in_halt = rst_n && (r_state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= c_FLUSH_LAST;
      r_halt_stat <= c_STAT_AOK;
    end else begin
      case (r_state)
        ST_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        ST_RUN: begin
          if (is_exc(W_stat)) begin
            r_state     <= ST_HALTED;
            r_halt_stat <= W_stat;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_FLUSH;
        end
      endcase
    end
  end

  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    W_bubble = 1'b1;
    set_cc   = 1'b0;
    if (w_in_run) begin
      F_stall  = w_lu || w_rt;
      D_stall  = w_lu;
      // Load-use stall dominates in D so stall and bubble never coincide.
      D_bubble = !w_lu && (w_mp || w_rt);
      E_bubble = w_mp || w_lu;
      M_bubble = w_exc;
      W_stall  = is_exc(W_stat);
      W_bubble = 1'b0;
      set_cc   = (E_icode == c_I_OPQ) && !w_exc;
    end else if (w_in_halt) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      W_bubble = 1'b0;
      set_cc   = 1'b0;
    end
  end

  assign E_stall   = 1'b0;
  assign M_stall   = 1'b0;
  assign halted    = w_in_halt;
  assign halt_stat = r_halt_stat;

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk     (clk),
    .i_clear (!rst_n),
    .i_inc   (w_in_run),
    .o_cnt   (cyc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk     (clk),
    .i_clear (!rst_n),
    .i_inc   (w_in_run && w_lu),
    .o_cnt   (lu_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
    .clk     (clk),
    .i_clear (!rst_n),
    .i_inc   (w_in_run && w_mp),
    .o_cnt   (mp_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
    .clk     (clk),
    .i_clear (!rst_n),
    .i_inc   (w_in_run && w_rt && !w_lu),
    .o_cnt   (ret_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : random stimulus vs behavioural model; r1.0   |
// +--------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  localparam int FLUSH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [1:0] m_stat, W_stat;

  logic        a_F_stall, a_D_stall, a_D_bubble, a_E_stall, a_E_bubble;
  logic        a_M_stall, a_M_bubble, a_W_stall, a_W_bubble, a_set_cc, a_halted;
  logic [1:0]  a_halt_stat;
  logic [31:0] a_cyc, a_lu, a_mp, a_ret;

  logic        b_F_stall, b_D_stall, b_D_bubble, b_E_stall, b_E_bubble;
  logic        b_M_stall, b_M_bubble, b_W_stall, b_W_bubble, b_set_cc, b_halted;
  logic [1:0]  b_halt_stat;
  logic [3:0]  b_cyc, b_lu, b_mp, b_ret;

  pipe_hazard_ctrl #(.CNT_W(32), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(a_F_stall), .D_stall(a_D_stall), .D_bubble(a_D_bubble),
    .E_stall(a_E_stall), .E_bubble(a_E_bubble), .M_stall(a_M_stall),
    .M_bubble(a_M_bubble), .W_stall(a_W_stall), .W_bubble(a_W_bubble),
    .set_cc(a_set_cc), .halted(a_halted), .halt_stat(a_halt_stat),
    .cyc_cnt(a_cyc), .lu_cnt(a_lu), .mp_cnt(a_mp), .ret_cnt(a_ret)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .FLUSH_CYCLES(FLUSH)) dut4 (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(b_F_stall), .D_stall(b_D_stall), .D_bubble(b_D_bubble),
    .E_stall(b_E_stall), .E_bubble(b_E_bubble), .M_stall(b_M_stall),
    .M_bubble(b_M_bubble), .W_stall(b_W_stall), .W_bubble(b_W_bubble),
    .set_cc(b_set_cc), .halted(b_halted), .halt_stat(b_halt_stat),
    .cyc_cnt(b_cyc), .lu_cnt(b_lu), .mp_cnt(b_mp), .ret_cnt(b_ret)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flush cycles still owed, halt flag, saturating counts.
  bit         m_valid = 1'b0;
  int         m_rem;
  bit         m_halt;
  logic [1:0] m_hstat;
  longint     cnt32[4];
  longint     cnt4[4];

  function automatic bit f_lu();
    return (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'hF &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction
  function automatic bit f_mp();
    return E_icode == 4'd7 && !e_Cnd;
  endfunction
  function automatic bit f_rt();
    return D_icode == 4'd9 || E_icode == 4'd9 || M_icode == 4'd9;
  endfunction
  function automatic bit f_exc();
    return m_stat != 2'd0 || W_stat != 2'd0;
  endfunction

  // {F_stall,D_stall,D_bubble,E_stall,E_bubble,M_stall,M_bubble,W_stall,W_bubble,set_cc,halted}
  function automatic logic [10:0] exp_vec();
    bit lu, mp, rt, exc;
    lu = f_lu(); mp = f_mp(); rt = f_rt(); exc = f_exc();
    if (!rst_n || m_rem > 0)
      return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    if (m_halt)
      return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    return {lu | rt, lu, !lu & (mp | rt), 1'b0, mp | lu, 1'b0, exc,
            W_stat != 2'd0, 1'b0, (E_icode == 4'd6) & !exc, 1'b0};
  endfunction

  always @(posedge clk) begin
    bit inc[4];
    if (!rst_n) begin
      m_valid = 1'b1;
      m_rem   = FLUSH;
      m_halt  = 1'b0;
      m_hstat = 2'd0;
      for (int i = 0; i < 4; i++) begin cnt32[i] = 0; cnt4[i] = 0; end
    end else if (m_valid) begin
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end else if (!m_halt) begin
        inc[0] = 1'b1; inc[1] = f_lu(); inc[2] = f_mp(); inc[3] = f_rt() && !f_lu();
        for (int i = 0; i < 4; i++) begin
          if (inc[i]) begin
            if (cnt32[i] < 64'hFFFF_FFFF) cnt32[i] = cnt32[i] + 1;
            if (cnt4[i] < 15) cnt4[i] = cnt4[i] + 1;
          end
        end
        if (W_stat != 2'd0) begin
          m_halt  = 1'b1;
          m_hstat = W_stat;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [10:0] ev;
    if (m_valid) begin
      ev = exp_vec();
      chk("ctl", {a_F_stall, a_D_stall, a_D_bubble, a_E_stall, a_E_bubble, a_M_stall,
                  a_M_bubble, a_W_stall, a_W_bubble, a_set_cc, a_halted}, ev);
      chk("ctl4", {b_F_stall, b_D_stall, b_D_bubble, b_E_stall, b_E_bubble, b_M_stall,
                   b_M_bubble, b_W_stall, b_W_bubble, b_set_cc, b_halted}, ev);
      chk("halt_stat", a_halt_stat, m_hstat);
      chk("halt_stat4", b_halt_stat, m_hstat);
      chk("cyc_cnt", a_cyc, cnt32[0]);
      chk("lu_cnt", a_lu, cnt32[1]);
      chk("mp_cnt", a_mp, cnt32[2]);
      chk("ret_cnt", a_ret, cnt32[3]);
      chk("cyc_cnt4", b_cyc, cnt4[0]);
      chk("lu_cnt4", b_lu, cnt4[1]);
      chk("mp_cnt4", b_mp, cnt4[2]);
      chk("ret_cnt4", b_ret, cnt4[3]);
      chk("stall_bubble_excl", {a_D_stall & a_D_bubble, a_E_stall & a_E_bubble,
                                a_M_stall & a_M_bubble, a_W_stall & a_W_bubble}, 4'd0);
    end
  end

  task automatic set_in(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ei, input logic [3:0] dm, input logic cnd,
                        input logic [3:0] mi, input logic [1:0] ms, input logic [1:0] ws);
    D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = dm;
    e_Cnd = cnd; M_icode = mi; m_stat = ms; W_stat = ws;
  endtask

  task automatic idle();
    set_in(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 4'd1, 2'd0, 2'd0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [3:0] e_pick[6];
    e_pick[0] = 4'd5; e_pick[1] = 4'd11; e_pick[2] = 4'd7;
    e_pick[3] = 4'd6; e_pick[4] = 4'd9;  e_pick[5] = 4'd1;

    rst_n = 1'b0;
    idle();
    next(); next();
    rst_n = 1'b1;

    for (int i = 0; i < FLUSH; i++) begin
      @(negedge clk);
      chk("flush_F_stall", a_F_stall, 1'b1);
      chk("flush_W_bubble", a_W_bubble, 1'b1);
      next();
    end
    @(negedge clk);
    chk("run_D_bubble", a_D_bubble, 1'b0);
    chk("run_halted", a_halted, 1'b0);
    chk("run_cyc0", a_cyc, 32'd0);
    next();

    set_in(4'd1, 4'd3, 4'hF, 4'd5, 4'd3, 1'b0, 4'd1, 2'd0, 2'd0);
    @(negedge clk);
    chk("lu_F_stall", a_F_stall, 1'b1);
    chk("lu_D_stall", a_D_stall, 1'b1);
    chk("lu_E_bubble", a_E_bubble, 1'b1);
    chk("lu_D_bubble", a_D_bubble, 1'b0);
    next();

    set_in(4'd1, 4'd3, 4'hF, 4'd5, 4'hF, 1'b0, 4'd1, 2'd0, 2'd0);
    @(negedge clk);
    chk("lu_cnt_1", a_lu, 32'd1);
    chk("rnone_D_stall", a_D_stall, 1'b0);
    chk("rnone_F_stall", a_F_stall, 1'b0);
    next();

    set_in(4'd9, 4'hF, 4'hF, 4'd7, 4'hF, 1'b0, 4'd1, 2'd0, 2'd0);
    @(negedge clk);
    chk("mp_D_bubble", a_D_bubble, 1'b1);
    chk("mp_E_bubble", a_E_bubble, 1'b1);
    chk("mp_F_stall", a_F_stall, 1'b1);
    next();

    set_in(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1'b0, 4'd1, 2'd2, 2'd0);
    @(negedge clk);
    chk("mp_cnt_1", a_mp, 32'd1);
    chk("ret_cnt_1", a_ret, 32'd1);
    chk("exc_set_cc", a_set_cc, 1'b0);
    chk("exc_M_bubble", a_M_bubble, 1'b1);
    next();

    set_in(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1'b0, 4'd1, 2'd0, 2'd0);
    @(negedge clk);
    chk("opq_set_cc", a_set_cc, 1'b1);
    next();

    set_in(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 4'd1, 2'd0, 2'd2);
    @(negedge clk);
    chk("pre_halt_W_stall", a_W_stall, 1'b1);
    chk("pre_halt_halted", a_halted, 1'b0);
    next();

    for (int i = 0; i < 3; i++) begin
      set_in(4'($urandom_range(0, 11)), rnd_reg(), rnd_reg(), e_pick[$urandom_range(0, 5)],
             rnd_reg(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 2'd0, 2'd0);
      @(negedge clk);
      chk("halted", a_halted, 1'b1);
      chk("halt_stat_adr", a_halt_stat, 2'd2);
      chk("halt_cyc_frozen", a_cyc, 32'd7);
      chk("halt_D_bubble", a_D_bubble, 1'b0);
      next();
    end

    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_cycle_halted", a_halted, 1'b0);
    chk("rst_cycle_F_stall", a_F_stall, 1'b1);
    next();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reflush_halt_stat", a_halt_stat, 2'd0);
    chk("reflush_cyc", a_cyc, 32'd0);
    chk("reflush_D_bubble", a_D_bubble, 1'b1);
    repeat (FLUSH) next();
    repeat (20) next();
    @(negedge clk);
    chk("cyc_20", a_cyc, 32'd20);
    chk("cyc4_saturated", b_cyc, 4'd15);
    next();

    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      set_in(($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 11)),
             rnd_reg(), rnd_reg(), e_pick[$urandom_range(0, 5)], rnd_reg(),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom_range(0, 11)),
             ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
             ($urandom_range(0, 149) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
      next();
    end

    rst_n = 1'b1;
    idle();
    next(); next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage Y86-64 core.
- Generates the stall/bubble pair for each of the F, D, E, M and W pipeline registers, and gates condition-code updates.
- Owns a small run-state FSM: post-reset flush, run, sticky halt on a non-AOK write-back status.
- Keeps saturating hazard performance counters.
- Sits beside the datapath; its outputs drive the stall/bubble inputs of every pipeline register instance.

Parameters:
- CNT_W, 32, width of each performance counter.
- FLUSH_CYCLES, 4, number of post-reset cycles during which all downstream registers are bubbled (min 1, max 15).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- D_icode  in  4  icode in D register.
- d_srcA  in  4  decode source A (4'hF = none).
- d_srcB  in  4  decode source B (4'hF = none).
- E_icode  in  4  icode in E register.
- E_dstM  in  4  E-stage memory destination.
- e_Cnd  in  1  execute-stage branch condition.
- M_icode  in  4  icode in M register.
- m_stat  in  2  memory-stage status.
- W_stat  in  2  write-back status.
- F_stall  out  1  hold F (PC) register.
- D_stall, D_bubble  out  1 each  D register control.
- E_stall, E_bubble  out  1 each  E register control (E_stall is always 0).
- M_stall, M_bubble  out  1 each  M register control (M_stall is always 0).
- W_stall, W_bubble  out  1 each  W register control.
- set_cc  out  1  enable CC write this cycle.
- halted  out  1  sticky halt indicator.
- halt_stat  out  2  W_stat captured on halt entry.
- cyc_cnt, lu_cnt, mp_cnt, ret_cnt  out  CNT_W each  performance counters.

Behaviour:
- Encodings:
  - stat: AOK=0, HLT=1, ADR=2, INS=3.
  - icode: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
  - RNONE=F.
- Combinational hazard terms, evaluated in the same cycle as their inputs (no latency):
  - lu = E_icode∈{MRMOVQ,POPQ} and E_dstM≠RNONE and E_dstM∈{d_srcA,d_srcB}.
  - mp = E_icode==JXX and !e_Cnd.
  - rt = RET∈{D_icode,E_icode,M_icode}.
  - exc = m_stat∈{ADR,INS,HLT} or W_stat∈{ADR,INS,HLT}.
- FSM states:
  - FLUSH (reset state): 4-bit counter runs from FLUSH_CYCLES-1 down to 0. D_bubble=E_bubble=M_bubble=W_bubble=1, F_stall=1, all other outputs 0. Transitions to RUN the cycle after the counter reaches 0.
  - RUN:
    - F_stall = lu|rt.
    - D_stall = lu.
    - D_bubble = mp | (rt & !lu).
    - E_bubble = mp|lu.
    - M_bubble = exc.
    - W_stall = (W_stat≠AOK).
    - W_bubble = 0.
    - set_cc = (E_icode==OPQ) & !exc.
    - Transitions to HALTED on the edge where W_stat≠AOK, latching halt_stat<=W_stat.
  - HALTED (sticky until rst_n=0): F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, halted=1.
- Exclusivity: on no cycle may any stage's stall and bubble both be 1. The register treats stall&bubble as a normal load, so a conflict is a hard bug.
- Simultaneous lu and mp in RUN: E_bubble=1, D_stall=1, D_bubble=0. The stall wins in D.
- Counters are cleared by reset and saturate at all-ones (no wrap). In RUN only:
  - cyc_cnt increments every cycle.
  - lu_cnt increments on lu.
  - mp_cnt increments on mp.
  - ret_cnt increments on rt & !lu.
- Counters freeze in FLUSH and HALTED.
- Reset values: state=FLUSH, halted=0, halt_stat=AOK, all counters 0. Outputs during the reset cycle follow FLUSH rules.
- Reset asserted mid-RUN or in HALTED returns to FLUSH on the next edge and restarts the flush count.

Decomposition:
- Shared package y86_pkg holds the stat and icode localparams, RNONE, and the FSM state enum (FLUSH/RUN/HALTED).
- One natural sub-module: sat_counter (CNT_W, inc, clear), instantiated four times.

Test Plan:
- Reset, then release -> bubbles on D/E/M/W and F_stall=1 for exactly 4 cycles; RUN on cycle 5; all counters 0.
- E_icode=MRMOVQ, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt +1.
- Same as above but E_dstM=F, d_srcB=F -> no stall (RNONE never matches).
- E_icode=JXX, e_Cnd=0, D_icode=RET -> D_bubble=1, E_bubble=1, F_stall=1; mp_cnt and ret_cnt each +1.
- Load-use and mispredict in the same cycle -> D_stall=1, D_bubble=0, E_bubble=1.
- m_stat=ADR with E_icode=OPQ -> set_cc=0, M_bubble=1.
- Next cycle W_stat=ADR -> HALTED, halted=1, halt_stat=2, counters frozen; rst_n low one cycle -> back to FLUSH.
- Drive cyc_cnt to 2^CNT_W-1 (CNT_W=4 build) -> holds at 15, never wraps.
- Assertion: every cycle, no stage has stall & bubble simultaneously.
